// File: rtl/approx_mul_mac_accum.sv
// rtl/approx_mul_mac_accum.sv - frame accumulator for approximate multiplier products
//
// Sums a frame of up to LEN unsigned PROD_W-bit products into a saturating ACC_W-bit
// accumulator and presents the frame sum, beat count and saturation flag on a
// valid/ready output.
//
// Optional feature macro: APPROX_BIAS_COMP_EN
//   defined   : each product is increased by BIAS_COMP before accumulation
//   undefined : products are accumulated as-is
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   async active-low reset
//   in_valid   in   product beat valid
//   in_ready   out  stage can accept a beat (depends on state only)
//   in_prod    in   approximate product, PROD_W bits
//   in_last    in   beat closes current frame
//   out_valid  out  frame result valid
//   out_ready  in   consumer accepts result
//   out_sum    out  saturated frame sum, ACC_W bits
//   out_count  out  beats in frame (1..LEN)
//   out_sat    out  sum saturated at some point in frame
module approx_mul_mac_accum #(
  parameter int PROD_W    = 16,
  parameter int ACC_W     = 24,
  parameter int LEN       = 16,
  parameter int BIAS_COMP = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PROD_W-1:0]          in_prod,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_sum,
  output logic [$clog2(LEN+1)-1:0]   out_count,
  output logic                       out_sat
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  // Elaboration-time guard against unsupported parameter sets.
  if (ACC_W < PROD_W || LEN < 1 || BIAS_COMP < 0 || BIAS_COMP >= 2**PROD_W) begin : g_bad_param
    $error("approx_mul_mac_accum: unsupported parameters");
  end

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               osat_q, osat_d;

  logic [ACC_W:0]     add;
  logic [ACC_W:0]     acc_n;
  logic [ACC_W-1:0]   acc_new;
  logic               ovf;
  logic               sat_new;
  logic               close;

`ifdef APPROX_BIAS_COMP_EN
  localparam logic [PROD_W-1:0] BIAS_V = PROD_W'(BIAS_COMP);
  assign add = {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod} + {{(ACC_W + 1 - PROD_W){1'b0}}, BIAS_V};
`else
  assign add = {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
`endif

  // One extra bit catches the carry out; any carry clamps the sum to all-ones.
  assign acc_n   = {1'b0, acc_q} + add;
  assign ovf     = acc_n[ACC_W];
  assign acc_new = ovf ? {ACC_W{1'b1}} : acc_n[ACC_W-1:0];
  assign sat_new = sat_q | ovf;
  // in_last on the LEN-th beat still yields exactly one close.
  assign close   = in_last | (cnt_q == LAST_CNT);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    sum_d     = sum_q;
    count_d   = count_q;
    osat_d    = osat_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = acc_new;
          cnt_d = cnt_q + 1'b1;
          sat_d = sat_new;
          if (close) begin
            sum_d   = acc_new;
            count_d = cnt_q + 1'b1;
            osat_d  = sat_new;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        // No bypass: the next frame's first beat is taken no earlier than the following cycle.
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
      osat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      osat_q  <= osat_d;
    end
  end

  assign out_sum   = sum_q;
  assign out_count = count_q;
  assign out_sat   = osat_q;

endmodule

// File: tb/tb_approx_mul_mac_accum.sv
// tb/tb_approx_mul_mac_accum.sv - directed-vector bench for approx_mul_mac_accum
module tb_approx_mul_mac_accum;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_prod;
  logic        in_last;
  logic        out_ready;

  logic        in_ready, out_valid, out_sat;
  logic [23:0] out_sum;
  logic [4:0]  out_count;

  logic        s_in_ready, s_out_valid, s_out_sat;
  logic [16:0] s_out_sum;
  logic [4:0]  s_out_count;

  int vectors = 0;
  int errors  = 0;

`ifdef APPROX_BIAS_COMP_EN
  localparam int BIAS = 32;
`else
  localparam int BIAS = 0;
`endif

  approx_mul_mac_accum #(.PROD_W(16), .ACC_W(24), .LEN(16), .BIAS_COMP(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_sat(out_sat)
  );

  // Narrow accumulator sharing the same stimulus; frame closing does not depend on sums,
  // so both instances stay in lockstep.
  approx_mul_mac_accum #(.PROD_W(16), .ACC_W(17), .LEN(16), .BIAS_COMP(32)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_sum(s_out_sum), .out_count(s_out_count), .out_sat(s_out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [15:0] p, input logic last);
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0d want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0d want 1", in_ready); end
    vectors++; if (out_sum !== 24'd0) begin errors++; $display("FAIL reset_out_sum got %0d want 0", out_sum); end
    vectors++; if (out_count !== 5'd0) begin errors++; $display("FAIL reset_out_count got %0d want 0", out_count); end
    vectors++; if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat got %0d want 0", out_sat); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_frame();
    out_ready = 1'b1;
    send(16'd100, 1'b0);
    send(16'd200, 1'b0);
    send(16'd300, 1'b0);
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL frame_early_valid got %0d want 0", out_valid); end
    send(16'd400, 1'b1);
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL frame_out_valid got %0d want 1", out_valid); end
    vectors++; if (out_sum !== 24'd1000 + 24'(4 * BIAS)) begin errors++; $display("FAIL frame_sum got %0d want %0d", out_sum, 1000 + 4 * BIAS); end
    vectors++; if (out_count !== 5'd4) begin errors++; $display("FAIL frame_count got %0d want 4", out_count); end
    vectors++; if (out_sat !== 1'b0) begin errors++; $display("FAIL frame_sat got %0d want 0", out_sat); end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL frame_in_ready got %0d want 0", in_ready); end
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL frame_release got %0d want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL frame_ready_back got %0d want 1", in_ready); end
  endtask

  task automatic test_len_close();
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) send(16'd1, 1'b0);
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL len_beat15_valid got %0d want 0", out_valid); end
    send(16'd1, 1'b0);
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL len_out_valid got %0d want 1", out_valid); end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL len_in_ready got %0d want 0", in_ready); end
    vectors++; if (out_sum !== 24'(16 + 16 * BIAS)) begin errors++; $display("FAIL len_sum got %0d want %0d", out_sum, 16 + 16 * BIAS); end
    vectors++; if (out_count !== 5'd16) begin errors++; $display("FAIL len_count got %0d want 16", out_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send(16'd100, 1'b0);
    send(16'd200, 1'b0);
    send(16'd300, 1'b0);
    send(16'd400, 1'b1);
    in_valid = 1'b1; in_prod = 16'd999; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL hold_handshake cyc %0d got valid=%0d ready=%0d want 1/0", i, out_valid, in_ready); end
      vectors++; if (out_sum !== 24'd1000 + 24'(4 * BIAS) || out_count !== 5'd4 || out_sat !== 1'b0) begin
        errors++; $display("FAIL hold_stable cyc %0d got sum=%0d count=%0d sat=%0d want %0d/4/0", i, out_sum, out_count, out_sat, 1000 + 4 * BIAS);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_release got valid=%0d ready=%0d want 0/1", out_valid, in_ready); end
    send(16'd5, 1'b1);
    vectors++; if (out_sum !== 24'(5 + BIAS) || out_count !== 5'd1) begin errors++; $display("FAIL after_release got sum=%0d count=%0d want %0d/1", out_sum, out_count, 5 + BIAS); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    send(16'd65535, 1'b0);
    send(16'd65535, 1'b0);
    send(16'd65535, 1'b1);
    vectors++; if (s_out_valid !== 1'b1) begin errors++; $display("FAIL sat_valid got %0d want 1", s_out_valid); end
    vectors++; if (s_out_sum !== 17'd131071) begin errors++; $display("FAIL sat_sum got %0d want 131071", s_out_sum); end
    vectors++; if (s_out_sat !== 1'b1) begin errors++; $display("FAIL sat_flag got %0d want 1", s_out_sat); end
    vectors++; if (s_out_count !== 5'd3) begin errors++; $display("FAIL sat_count got %0d want 3", s_out_count); end
    vectors++; if (out_sum !== 24'(196605 + 3 * BIAS) || out_sat !== 1'b0) begin errors++; $display("FAIL wide_nosat got sum=%0d sat=%0d want %0d/0", out_sum, out_sat, 196605 + 3 * BIAS); end
    @(posedge clk); #1;
    send(16'd1, 1'b0);
    send(16'd2, 1'b1);
    vectors++; if (s_out_sat !== 1'b0 || s_out_sum !== 17'(3 + 2 * BIAS)) begin errors++; $display("FAIL sat_next_frame got sum=%0d sat=%0d want %0d/0", s_out_sum, s_out_sat, 3 + 2 * BIAS); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(16'd5, 1'b0);
    send(16'd7, 1'b0);
    rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midreset_handshake got valid=%0d ready=%0d want 0/1", out_valid, in_ready); end
    vectors++; if (out_sum !== 24'd0 || out_count !== 5'd0 || out_sat !== 1'b0) begin errors++; $display("FAIL midreset_outputs got sum=%0d count=%0d sat=%0d want 0/0/0", out_sum, out_count, out_sat); end
    @(negedge clk);
    rst_n = 1'b1;
    send(16'd5, 1'b0);
    send(16'd7, 1'b1);
    vectors++; if (out_sum !== 24'(12 + 2 * BIAS) || out_count !== 5'd2) begin errors++; $display("FAIL postreset_frame got sum=%0d count=%0d want %0d/2", out_sum, out_count, 12 + 2 * BIAS); end
    @(posedge clk); #1;
  endtask

  task automatic test_bias();
    out_ready = 1'b1;
    send(16'd0, 1'b0);
    send(16'd10, 1'b1);
`ifdef APPROX_BIAS_COMP_EN
    vectors++; if (out_sum !== 24'd74) begin errors++; $display("FAIL bias_sum got %0d want 74", out_sum); end
`else
    vectors++; if (out_sum !== 24'd10) begin errors++; $display("FAIL bias_sum got %0d want 10", out_sum); end
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_len_close();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    test_bias();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
